// File: rtl/multi_phase_pulse_gen_if.sv
// Handshake/bus bundle for multi_phase_pulse_gen.
// Carries control inputs (start, abort, loop_en, hold_last, pulse_len and,
// when PHASE_GAP_EN is defined, gap_len) plus the registered phase outputs
// (ph, ch_idx, busy, done). master drives controls; slave is the generator.
interface multi_phase_pulse_gen_if #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 16,
    parameter int IDX_W  = $clog2(NUM_CH)
);
    logic              start;
    logic              abort;
    logic              loop_en;
    logic              hold_last;
    logic [CNT_W-1:0]  pulse_len;
`ifdef PHASE_GAP_EN
    logic [CNT_W-1:0]  gap_len;
`endif
    logic [NUM_CH-1:0] ph;
    logic [IDX_W-1:0]  ch_idx;
    logic              busy;
    logic              done;

`ifdef PHASE_GAP_EN
    modport master (
        output start, abort, loop_en, hold_last, pulse_len, gap_len,
        input  ph, ch_idx, busy, done
    );
    modport slave (
        input  start, abort, loop_en, hold_last, pulse_len, gap_len,
        output ph, ch_idx, busy, done
    );
`else
    modport master (
        output start, abort, loop_en, hold_last, pulse_len,
        input  ph, ch_idx, busy, done
    );
    modport slave (
        input  start, abort, loop_en, hold_last, pulse_len,
        output ph, ch_idx, busy, done
    );
`endif
endinterface

// File: rtl/multi_phase_pulse_gen.sv
// N-channel sequential one-hot phase generator: one-shot, loop, hold-last.
// Ports: clk, rst (async active-low), bus (slave modport: start, abort,
// loop_en, hold_last, pulse_len[, gap_len] in; ph, ch_idx, busy, done out).
// Optional macro PHASE_GAP_EN adds gap_len and an inter-phase GAP state.
module multi_phase_pulse_gen #(
    parameter int NUM_CH     = 3,
    parameter int CNT_W      = 16,
    parameter int LOOP_START = 1,
    parameter int IDX_W      = $clog2(NUM_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    multi_phase_pulse_gen_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
`ifdef PHASE_GAP_EN
        S_GAP,
`endif
        S_HOLD
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] LOOP_IDX = IDX_W'(LOOP_START);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    function automatic logic [NUM_CH-1:0] f_onehot(
        input logic [IDX_W-1:0] i
    );
        logic [NUM_CH-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    state_t            r_state;
    logic [NUM_CH-1:0] r_ph;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_len;
    logic              r_loop;
    logic              r_hold;
`ifdef PHASE_GAP_EN
    logic [CNT_W-1:0]  r_gap;
    logic [CNT_W-1:0]  w_gap;
`endif

    state_t            w_state;
    logic [NUM_CH-1:0] w_ph;
    logic [IDX_W-1:0]  w_idx;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_done;
    logic [CNT_W-1:0]  w_len;
    logic              w_loop;
    logic              w_hold;
    logic              w_adv;
    logic [IDX_W-1:0]  w_adv_idx;
    logic              w_last_cnt;

    assign w_last_cnt = (r_cnt == r_len - ONE_CNT);

    always_comb begin
        w_state   = r_state;
        w_ph      = r_ph;
        w_idx     = r_idx;
        w_cnt     = r_cnt;
        w_done    = 1'b0;
        w_len     = r_len;
        w_loop    = r_loop;
        w_hold    = r_hold;
`ifdef PHASE_GAP_EN
        w_gap     = r_gap;
`endif
        w_adv     = 1'b0;
        w_adv_idx = r_idx;

        unique case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_len   = (bus.pulse_len == '0) ? ONE_CNT
                                                    : bus.pulse_len;
                    w_loop  = bus.loop_en;
                    w_hold  = bus.hold_last;
`ifdef PHASE_GAP_EN
                    w_gap   = bus.gap_len;
`endif
                    w_idx   = '0;
                    w_ph    = f_onehot('0);
                    w_cnt   = '0;
                    w_state = S_PULSE;
                end
            end
            S_PULSE: begin
                if (!w_last_cnt) begin
                    w_cnt = r_cnt + ONE_CNT;
                end else if (r_idx != LAST_IDX) begin
                    w_adv     = 1'b1;
                    w_adv_idx = r_idx + IDX_W'(1);
                end else if (r_hold) begin
                    w_state = S_HOLD;
                    w_cnt   = '0;
                end else if (r_loop) begin
                    w_adv     = 1'b1;
                    w_adv_idx = LOOP_IDX;
                    w_done    = 1'b1;
                end else begin
                    w_state = S_IDLE;
                    w_ph    = '0;
                    w_idx   = '0;
                    w_cnt   = '0;
                    w_done  = 1'b1;
                end
            end
`ifdef PHASE_GAP_EN
            S_GAP: begin
                if (r_cnt == r_gap - ONE_CNT) begin
                    w_state = S_PULSE;
                    w_ph    = f_onehot(r_idx);
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + ONE_CNT;
                end
            end
`endif
            S_HOLD: begin
                if (bus.start) begin
                    w_adv     = 1'b1;
                    w_adv_idx = LOOP_IDX;
                    w_done    = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_ph    = '0;
                w_idx   = '0;
                w_cnt   = '0;
            end
        endcase

        // Channel advance: a non-zero gap inserts a dark GAP period
        // with ch_idx already pointing at the upcoming channel.
        if (w_adv) begin
            w_idx = w_adv_idx;
            w_cnt = '0;
`ifdef PHASE_GAP_EN
            if (r_gap != '0) begin
                w_state = S_GAP;
                w_ph    = '0;
            end else begin
                w_state = S_PULSE;
                w_ph    = f_onehot(w_adv_idx);
            end
`else
            w_state = S_PULSE;
            w_ph    = f_onehot(w_adv_idx);
`endif
        end

        // Abort overrides every transition outside IDLE.
        if (bus.abort && r_state != S_IDLE) begin
            w_state = S_IDLE;
            w_ph    = '0;
            w_idx   = '0;
            w_cnt   = '0;
            w_done  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ph    <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_len   <= '0;
            r_loop  <= 1'b0;
            r_hold  <= 1'b0;
`ifdef PHASE_GAP_EN
            r_gap   <= '0;
`endif
        end else begin
            r_state <= w_state;
            r_ph    <= w_ph;
            r_idx   <= w_idx;
            r_cnt   <= w_cnt;
            r_busy  <= (w_state != S_IDLE);
            r_done  <= w_done;
            r_len   <= w_len;
            r_loop  <= w_loop;
            r_hold  <= w_hold;
`ifdef PHASE_GAP_EN
            r_gap   <= w_gap;
`endif
        end
    end

    assign bus.ph     = r_ph;
    assign bus.ch_idx = r_idx;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

endmodule

// File: tb/tb_multi_phase_pulse_gen.sv
// Bench for multi_phase_pulse_gen: timeline-queue reference model,
// directed literal scenarios and randomized stimulus.
module tb_multi_phase_pulse_gen;

    localparam int NUM_CH     = 3;
    localparam int CNT_W      = 16;
    localparam int LOOP_START = 1;
    localparam int IDX_W      = $clog2(NUM_CH);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multi_phase_pulse_gen_if #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W)
    ) bus ();

    multi_phase_pulse_gen #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W),
        .LOOP_START(LOOP_START), .IDX_W(IDX_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [NUM_CH-1:0] ph;
        logic [IDX_W-1:0]  idx;
        logic              busy;
        logic              done;
    } exp_t;

    // Model: the future output timeline is a queue; cur is what the
    // outputs must show after the most recent edge.
    exp_t q[$];
    exp_t cur;
    bit   in_hold;
    bit   m_loop;
    bit   m_hold;
    int   m_len;
    int   m_gap;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                     nm, cyc, act, req);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cur     = '0;
        in_hold = 1'b0;
    endtask

    task automatic push_seg(input int first, input bit lead,
                            input bit mark);
        exp_t e;
        bit   d;
        d = mark;
        for (int c = first; c < NUM_CH; c++) begin
            if (m_gap > 0 && (c != first || lead)) begin
                for (int g = 0; g < m_gap; g++) begin
                    e.ph   = '0;
                    e.idx  = IDX_W'(c);
                    e.busy = 1'b1;
                    e.done = d;
                    d      = 1'b0;
                    q.push_back(e);
                end
            end
            for (int k = 0; k < m_len; k++) begin
                e.ph    = '0;
                e.ph[c] = 1'b1;
                e.idx   = IDX_W'(c);
                e.busy  = 1'b1;
                e.done  = d;
                d       = 1'b0;
                q.push_back(e);
            end
        end
    endtask

    task automatic model_step(input bit s, input bit a,
                              input bit le, input bit hl,
                              input logic [CNT_W-1:0] pl,
                              input logic [CNT_W-1:0] gl);
        exp_t idle;
        idle = '0;
        if (cur.busy && a) begin
            q.delete();
            in_hold = 1'b0;
            cur     = idle;
        end else if (!cur.busy) begin
            if (s && !a) begin
                m_len   = (pl == 0) ? 1 : int'(pl);
                m_gap   = int'(gl);
                m_loop  = le;
                m_hold  = hl;
                in_hold = 1'b0;
                push_seg(0, 1'b0, 1'b0);
                cur = q.pop_front();
            end else begin
                cur = idle;
            end
        end else if (in_hold) begin
            if (s) begin
                in_hold = 1'b0;
                push_seg(LOOP_START, 1'b1, 1'b1);
                cur = q.pop_front();
            end
        end else if (q.size() == 0) begin
            if (m_hold) begin
                in_hold  = 1'b1;
                cur.done = 1'b0;
            end else if (m_loop) begin
                push_seg(LOOP_START, 1'b1, 1'b1);
                cur = q.pop_front();
            end else begin
                cur      = idle;
                cur.done = 1'b1;
            end
        end else begin
            cur = q.pop_front();
        end
    endtask

    // One clock: sample inputs before the edge, advance model, compare.
    task automatic tick();
        bit s, a, le, hl;
        logic [CNT_W-1:0] pl, gl;
        s  = bus.start;
        a  = bus.abort;
        le = bus.loop_en;
        hl = bus.hold_last;
        pl = bus.pulse_len;
`ifdef PHASE_GAP_EN
        gl = bus.gap_len;
`else
        gl = '0;
`endif
        @(posedge clk);
        #1;
        cyc++;
        model_step(s, a, le, hl, pl, gl);
        chk("ph",     32'(bus.ph),     32'(cur.ph));
        chk("ch_idx", 32'(bus.ch_idx), 32'(cur.idx));
        chk("busy",   32'(bus.busy),   32'(cur.busy));
        chk("done",   32'(bus.done),   32'(cur.done));
    endtask

    task automatic launch(input int len, input bit le, input bit hl);
        bus.pulse_len = CNT_W'(len);
        bus.loop_en   = le;
        bus.hold_last = hl;
        bus.start     = 1'b1;
        cyc           = -1;
        tick();
        bus.start     = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=done",
                 cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.loop_en   = 1'b0;
        bus.hold_last = 1'b0;
        bus.pulse_len = '0;
`ifdef PHASE_GAP_EN
        bus.gap_len   = '0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ph",   32'(bus.ph),     0);
        chk("rst_idx",  32'(bus.ch_idx), 0);
        chk("rst_busy", 32'(bus.busy),   0);
        chk("rst_done", 32'(bus.done),   0);
        rst = 1'b1;
        repeat (3) tick();

        // One-shot, L=5
        launch(5, 1'b0, 1'b0);
        chk("os_c0", 32'(bus.ph), 32'h1);
        while (cyc < 16) begin
            tick();
            if (cyc == 4)  chk("os_c4",  32'(bus.ph), 32'h1);
            if (cyc == 5)  chk("os_c5",  32'(bus.ph), 32'h2);
            if (cyc == 10) chk("os_c10", 32'(bus.ph), 32'h4);
            if (cyc == 14) chk("os_c14", 32'(bus.ph), 32'h4);
            if (cyc == 15) begin
                chk("os_c15_ph",   32'(bus.ph),   32'h0);
                chk("os_c15_done", 32'(bus.done), 32'h1);
                chk("os_c15_busy", 32'(bus.busy), 32'h0);
            end
            if (cyc == 16) chk("os_c16_done", 32'(bus.done), 32'h0);
        end

        // Loop, L=5, abort at 23
        launch(5, 1'b1, 1'b0);
        while (cyc < 23) begin
            tick();
            if (cyc == 15) begin
                chk("lp_c15_ph",   32'(bus.ph),   32'h2);
                chk("lp_c15_done", 32'(bus.done), 32'h1);
            end
            if (cyc == 16) chk("lp_c16_done", 32'(bus.done), 32'h0);
            if (cyc == 20) chk("lp_c20", 32'(bus.ph), 32'h4);
        end
        bus.abort = 1'b1;
        tick();
        chk("lp_ab_ph",   32'(bus.ph),   32'h0);
        chk("lp_ab_done", 32'(bus.done), 32'h0);
        chk("lp_ab_busy", 32'(bus.busy), 32'h0);
        bus.abort   = 1'b0;
        bus.loop_en = 1'b0;
        tick();

        // Hold-last, L=3, release at 106
        launch(3, 1'b0, 1'b1);
        while (cyc < 105) begin
            tick();
            if (cyc == 6) chk("hd_c6", 32'(bus.ph), 32'h4);
        end
        chk("hd_c105_ph",   32'(bus.ph),   32'h4);
        chk("hd_c105_busy", 32'(bus.busy), 32'h1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("hd_rel_ph",   32'(bus.ph),     32'h2);
        chk("hd_rel_done", 32'(bus.done),   32'h1);
        chk("hd_rel_idx",  32'(bus.ch_idx), 32'h1);
        while (cyc < 112) begin
            tick();
            if (cyc == 108) chk("hd_c108", 32'(bus.ph), 32'h2);
            if (cyc == 109) chk("hd_c109", 32'(bus.ph), 32'h4);
        end
        chk("hd_c112", 32'(bus.ph), 32'h4);
        bus.abort = 1'b1;
        tick();
        chk("hd_ab_busy", 32'(bus.busy), 32'h0);
        bus.abort     = 1'b0;
        bus.hold_last = 1'b0;
        tick();

        // pulse_len=0 behaves as 1; late change ignored
        launch(0, 1'b0, 1'b0);
        bus.pulse_len = CNT_W'(9);
        chk("z_c0", 32'(bus.ph), 32'h1);
        tick();
        chk("z_c1", 32'(bus.ph), 32'h2);
        tick();
        chk("z_c2", 32'(bus.ph), 32'h4);
        tick();
        chk("z_c3_ph",   32'(bus.ph),   32'h0);
        chk("z_c3_done", 32'(bus.done), 32'h1);
        tick();

        // Asynchronous reset mid-sequence
        launch(5, 1'b1, 1'b0);
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("ar_ph",   32'(bus.ph),   0);
        chk("ar_busy", 32'(bus.busy), 0);
        chk("ar_done", 32'(bus.done), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.loop_en = 1'b0;
        repeat (4) tick();
        chk("ar_idle", 32'(bus.ph), 0);

`ifdef PHASE_GAP_EN
        bus.gap_len = CNT_W'(2);
        launch(4, 1'b0, 1'b0);
        while (cyc < 16) begin
            tick();
            if (cyc == 3)  chk("g_c3",  32'(bus.ph), 32'h1);
            if (cyc == 4)  chk("g_c4",  32'(bus.ph), 32'h0);
            if (cyc == 5)  chk("g_c5i", 32'(bus.ch_idx), 32'h1);
            if (cyc == 6)  chk("g_c6",  32'(bus.ph), 32'h2);
            if (cyc == 11) chk("g_c11", 32'(bus.ph), 32'h0);
            if (cyc == 12) chk("g_c12", 32'(bus.ph), 32'h4);
        end
        chk("g_c16_done", 32'(bus.done), 32'h1);
        bus.gap_len = '0;
        launch(5, 1'b0, 1'b0);
        while (cyc < 15) begin
            tick();
            if (cyc == 5) chk("g0_c5", 32'(bus.ph), 32'h2);
        end
        chk("g0_c15_done", 32'(bus.done), 32'h1);
        tick();
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.start     = ($urandom_range(0, 7) == 0);
            bus.abort     = ($urandom_range(0, 39) == 0);
            bus.loop_en   = 1'($urandom_range(0, 1));
            bus.hold_last = ($urandom_range(0, 2) == 0);
            bus.pulse_len = CNT_W'($urandom_range(0, 4));
`ifdef PHASE_GAP_EN
            bus.gap_len   = CNT_W'($urandom_range(0, 3));
`endif
            tick();
            if (bus.ph & (bus.ph - 1'b1))
                chk("onehot", 32'(bus.ph), 0);
            if (bus.done && bus.abort)
                chk("done_abort", 32'(bus.done), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
